sata_cmd_sequencer: RTL and testbench
=====================================

# sata_cmd_sequencer

Command front-end that sits between the user command interface and the command port of `sata_core` (`ready_for_cmd` / `new_cmd` / `cmd_type` / `sector_count` / `sector_addr`). It queues tagged host commands in a parametrised FIFO. It splits each command into core transfers of at most `MAX_XFER` sectors with address advance, and drives the core's idle-level handshake. It supervises each transfer with a timeout and reports one completion (tag, error) per host command.

## Interface
- `ADDR_W`, 48: LBA width; addresses wrap modulo 2^ADDR_W.
- `CNT_W`, 32: host sector-count width.
- `MAX_XFER`, 256: max sectors per core command, range 1..2^CNT_W-1.
- `QDEPTH_LOG2`, 2: queue depth = 2^QDEPTH_LOG2 entries.
- `TAG_W`, 4: command tag width.
- `TIMEOUT_CYCLES`, 1000000: per-phase watchdog in `clk` cycles; 0 disables it.

- `clk` in 1: single clock for the whole block.
- `reset` in 1: asynchronous, active-high.
- `cmd_valid` in 1: host command present.
- `cmd_ready` out 1: queue not full.
- `cmd_type` in 2: passed unchanged to the core.
- `cmd_count` in CNT_W: total sectors.
- `cmd_addr` in ADDR_W: start LBA.
- `cmd_tag` in TAG_W: echoed on completion.
- `core_ready_for_cmd` in 1: core idle level.
- `core_new_cmd` out 1: one-cycle issue pulse.
- `core_cmd_type` out 2
- `core_sector_count` out 32: chunk size, zero-extended.
- `core_sector_addr` out ADDR_W: chunk start LBA.
- `done_valid` out 1: one-cycle completion pulse.
- `done_tag` out TAG_W: tag of the completed command.
- `done_error` out 1: 1 = timeout or zero-count command.
- `busy` out 1: state != IDLE.
- `queue_level` out QDEPTH_LOG2+1: current number of queued entries.

## Operation
- Push on `cmd_valid && cmd_ready`. `cmd_ready = (queue_level != depth)`.
- There is no bypass. A full queue refuses a push even in a cycle where it is popped.
- FSM states: IDLE, LOAD, ISSUE, WAIT_ACK, WAIT_DONE, REPORT.
- IDLE: if the queue is non-empty, pop and go to LOAD.
- LOAD: latch `remaining`, `addr`, `type`, `tag`.
  - If `remaining == 0`, go to REPORT with error = 1.
  - Otherwise go to ISSUE.
- ISSUE: wait for `core_ready_for_cmd == 1`, then:
  - drive `chunk = min(remaining, MAX_XFER)` on the core outputs,
  - pulse `core_new_cmd`,
  - go to WAIT_ACK and clear the watchdog.
- WAIT_ACK: wait for `core_ready_for_cmd == 0`, then go to WAIT_DONE and clear the watchdog.
- WAIT_DONE: wait for `core_ready_for_cmd == 1`, then:
  - `remaining -= chunk`,
  - `addr = (addr + chunk) mod 2^ADDR_W`,
  - go to ISSUE if `remaining != 0`, else go to REPORT with error = 0.
- Watchdog: counts in WAIT_ACK and in WAIT_DONE. When it reaches `TIMEOUT_CYCLES` (nonzero), go to REPORT with error = 1 and discard the remaining chunks. Queued commands are unaffected.
- REPORT: pulse `done_valid` with `done_tag` and `done_error`, then go to IDLE.
- Core outputs hold their value from the issue edge until the next issue.

## Timing
- Reset values: `cmd_ready` = 1; `core_new_cmd`, `done_valid`, `done_error`, `busy` = 0; `queue_level` = 0; all data outputs = 0; FSM = IDLE; queue emptied.
- `reset` mid-operation aborts the current command with no `done_valid`, and flushes the queue.
- Latency: a command accepted at edge N into an empty, idle queue, with `core_ready_for_cmd` = 1, gives `core_new_cmd` high for exactly the one cycle following edge N+3.
- `core_new_cmd` and `done_valid` are registered outputs, never high for more than 1 cycle.
- Gap between chunks: the chunk-N+1 issue edge comes at least 1 cycle after the edge where `core_ready_for_cmd` rise was sampled.
- `done_valid` is asserted 1 cycle after the final ready-rise sample, or after the timeout edge.
- A push and a pop in the same cycle leave `queue_level` unchanged.

## Test plan
- Single command, count=100, addr=0x10, `MAX_XFER`=256, core model (ready low 5 cycles after the pulse) -> one `core_new_cmd`, count=100, addr=0x10; `done_valid` with tag echoed and error=0.
- count=600, addr=0xFFFF_FFFF_FF00 -> three issues with counts 256/256/88 and addrs 0xFFFF_FFFF_FF00, 0x0000_0000_0000 (wrap), 0x0000_0000_0100; one completion.
- Push 5 commands back-to-back with depth 4 and the core stalled -> `cmd_ready` low after 4 pushes; the 5th is held until the first pop; completions in tag order.
- count=0 -> no `core_new_cmd`; `done_valid` with error=1 within 3 cycles of the pop.
- `TIMEOUT_CYCLES`=50 and the core never drops ready -> `done_error`=1 after 50 cycles in WAIT_ACK; the next queued command is issued normally.
- Assert `reset` during WAIT_DONE with 2 queued commands -> all outputs at reset values, `queue_level`=0, no completion pulse.

Source files
------------

// File: rtl/sata_cmd_sequencer_if.sv
// Host command, core command, completion and status signals of sata_cmd_sequencer.
// slave is the sequencer's view, master is the surrounding logic's view.
interface sata_cmd_sequencer_if #(
    parameter int ADDR_W      = 48,
    parameter int CNT_W       = 32,
    parameter int TAG_W       = 4,
    parameter int QDEPTH_LOG2 = 2
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [1:0]             cmd_type;
    logic [CNT_W-1:0]       cmd_count;
    logic [ADDR_W-1:0]      cmd_addr;
    logic [TAG_W-1:0]       cmd_tag;

    logic                   core_ready_for_cmd;
    logic                   core_new_cmd;
    logic [1:0]             core_cmd_type;
    logic [31:0]            core_sector_count;
    logic [ADDR_W-1:0]      core_sector_addr;

    logic                   done_valid;
    logic [TAG_W-1:0]       done_tag;
    logic                   done_error;

    logic                   busy;
    logic [QDEPTH_LOG2:0]   queue_level;

    modport slave (
        input  cmd_valid, cmd_type, cmd_count, cmd_addr, cmd_tag, core_ready_for_cmd,
        output cmd_ready, core_new_cmd, core_cmd_type, core_sector_count, core_sector_addr,
        output done_valid, done_tag, done_error, busy, queue_level
    );

    modport master (
        output cmd_valid, cmd_type, cmd_count, cmd_addr, cmd_tag, core_ready_for_cmd,
        input  cmd_ready, core_new_cmd, core_cmd_type, core_sector_count, core_sector_addr,
        input  done_valid, done_tag, done_error, busy, queue_level
    );
endinterface

// File: rtl/sata_cmd_sequencer.sv
// Queues tagged host commands, splits them into core transfers of at most MAX_XFER
// sectors, supervises each transfer with a watchdog and reports one completion per command.
module sata_cmd_sequencer #(
    parameter int ADDR_W         = 48,
    parameter int CNT_W          = 32,
    parameter int MAX_XFER       = 256,
    parameter int QDEPTH_LOG2    = 2,
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 reset,
    sata_cmd_sequencer_if.slave  bus
);
    localparam int DEPTH = 1 << QDEPTH_LOG2;
    localparam int ENT_W = 2 + CNT_W + ADDR_W + TAG_W;
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_REPORT
    } state_t;

    state_t state_reg, state_next;

    // ---------------- command queue ----------------
    logic [ENT_W-1:0]       mem [DEPTH];
    logic [ENT_W-1:0]       rd_data_reg;
    logic [QDEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [QDEPTH_LOG2:0]   level_reg;
    logic                   cmd_ready_int, push, pop;

    assign cmd_ready_int = (level_reg != (QDEPTH_LOG2+1)'(DEPTH));
    assign push          = bus.cmd_valid && cmd_ready_int;
    assign pop           = (state_reg == S_IDLE) && (level_reg != '0);

    // Storage and its registered read port carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= {bus.cmd_type, bus.cmd_count, bus.cmd_addr, bus.cmd_tag};
        if (pop)
            rd_data_reg <= mem[rd_ptr_reg];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + QDEPTH_LOG2'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + QDEPTH_LOG2'(1);
            if (push && !pop)
                level_reg <= level_reg + (QDEPTH_LOG2+1)'(1);
            else if (pop && !push)
                level_reg <= level_reg - (QDEPTH_LOG2+1)'(1);
        end
    end

    logic [1:0]        rd_type;
    logic [CNT_W-1:0]  rd_count;
    logic [ADDR_W-1:0] rd_addr;
    logic [TAG_W-1:0]  rd_tag;

    assign rd_type  = rd_data_reg[ENT_W-1 -: 2];
    assign rd_count = rd_data_reg[ADDR_W+TAG_W +: CNT_W];
    assign rd_addr  = rd_data_reg[TAG_W +: ADDR_W];
    assign rd_tag   = rd_data_reg[TAG_W-1:0];

    // ---------------- command context ----------------
    logic [CNT_W-1:0]  remaining_reg, chunk_reg, chunk_calc, remaining_left;
    logic [ADDR_W-1:0] addr_reg;
    logic [1:0]        type_reg;
    logic [TAG_W-1:0]  tag_reg;
    logic              err_reg;
    logic [WD_W-1:0]   wd_reg;
    logic              wd_hit;

    assign chunk_calc     = (remaining_reg > CNT_W'(MAX_XFER)) ? CNT_W'(MAX_XFER) : remaining_reg;
    assign remaining_left = remaining_reg - chunk_reg;
    assign wd_hit         = WD_EN && (wd_reg == WD_LAST);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:      if (level_reg != '0) state_next = S_LOAD;
            S_LOAD:      state_next = (rd_count == '0) ? S_REPORT : S_ISSUE;
            S_ISSUE:     if (bus.core_ready_for_cmd) state_next = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (!bus.core_ready_for_cmd) state_next = S_WAIT_DONE;
                else if (wd_hit)             state_next = S_REPORT;
            end
            S_WAIT_DONE: begin
                if (bus.core_ready_for_cmd)  state_next = (remaining_left != '0) ? S_ISSUE : S_REPORT;
                else if (wd_hit)             state_next = S_REPORT;
            end
            S_REPORT:    state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    logic load_en, issue_en, ack_en, adv_en, wd_run, wd_expire, report_en;

    always_comb begin
        load_en   = (state_reg == S_LOAD);
        issue_en  = (state_reg == S_ISSUE) && bus.core_ready_for_cmd;
        ack_en    = (state_reg == S_WAIT_ACK) && !bus.core_ready_for_cmd;
        adv_en    = (state_reg == S_WAIT_DONE) && bus.core_ready_for_cmd;
        wd_run    = (state_reg == S_WAIT_ACK) || (state_reg == S_WAIT_DONE);
        // A core response in the same cycle as the limit still wins over the timeout.
        wd_expire = wd_run && wd_hit && !ack_en && !adv_en;
        report_en = (state_reg == S_REPORT);
    end

    // ---------------- datapath and registered outputs ----------------
    logic              core_new_cmd_reg, done_valid_reg, done_error_reg;
    logic [1:0]        core_type_reg;
    logic [31:0]       core_count_reg;
    logic [ADDR_W-1:0] core_addr_reg;
    logic [TAG_W-1:0]  done_tag_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining_reg    <= '0;
            chunk_reg        <= '0;
            addr_reg         <= '0;
            type_reg         <= '0;
            tag_reg          <= '0;
            err_reg          <= 1'b0;
            wd_reg           <= '0;
            core_new_cmd_reg <= 1'b0;
            core_type_reg    <= '0;
            core_count_reg   <= '0;
            core_addr_reg    <= '0;
            done_valid_reg   <= 1'b0;
            done_tag_reg     <= '0;
            done_error_reg   <= 1'b0;
        end else begin
            core_new_cmd_reg <= issue_en;
            done_valid_reg   <= report_en;
            if (load_en) begin
                remaining_reg <= rd_count;
                addr_reg      <= rd_addr;
                type_reg      <= rd_type;
                tag_reg       <= rd_tag;
                err_reg       <= (rd_count == '0);
            end else if (wd_expire) begin
                err_reg       <= 1'b1;
            end
            if (issue_en) begin
                chunk_reg      <= chunk_calc;
                core_count_reg <= 32'(chunk_calc);
                core_addr_reg  <= addr_reg;
                core_type_reg  <= type_reg;
            end
            if (adv_en) begin
                remaining_reg <= remaining_left;
                addr_reg      <= addr_reg + ADDR_W'(chunk_reg);
            end
            if (issue_en || ack_en)
                wd_reg <= '0;
            else if (wd_run)
                wd_reg <= wd_reg + WD_W'(1);
            if (report_en) begin
                done_tag_reg   <= tag_reg;
                done_error_reg <= err_reg;
            end
        end
    end

    assign bus.cmd_ready         = cmd_ready_int;
    assign bus.core_new_cmd      = core_new_cmd_reg;
    assign bus.core_cmd_type     = core_type_reg;
    assign bus.core_sector_count = core_count_reg;
    assign bus.core_sector_addr  = core_addr_reg;
    assign bus.done_valid        = done_valid_reg;
    assign bus.done_tag          = done_tag_reg;
    assign bus.done_error        = done_error_reg;
    assign bus.busy              = (state_reg != S_IDLE);
    assign bus.queue_level       = level_reg;
endmodule

// File: tb/tb_sata_cmd_sequencer.sv
// Directed bench for sata_cmd_sequencer: vector table of single commands plus
// hand-written backpressure, timeout and mid-operation reset sequences.
module tb_sata_cmd_sequencer;
    localparam int ADDR_W = 48;
    localparam int CNT_W  = 32;
    localparam int TAG_W  = 4;
    localparam int QL2    = 2;
    localparam int TMO    = 50;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sata_cmd_sequencer_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .TAG_W(TAG_W), .QDEPTH_LOG2(QL2)) bus ();

    sata_cmd_sequencer #(
        .ADDR_W(ADDR_W), .CNT_W(CNT_W), .MAX_XFER(256), .QDEPTH_LOG2(QL2),
        .TAG_W(TAG_W), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] cnt;
        logic [47:0] addr;
        logic [1:0]  typ;
        int          cyc;
    } issue_t;
    typedef struct {
        logic [3:0] tag;
        logic       err;
        int         cyc;
    } done_t;

    issue_t iss_q[$];
    done_t  dn_q[$];
    logic   prev_new = 1'b0;
    logic   prev_done = 1'b0;
    int     dbl_new = 0;
    int     dbl_done = 0;

    // Monitor: one line per completed host command.
    always @(negedge clk) begin
        if (bus.core_new_cmd)
            iss_q.push_back('{bus.core_sector_count, bus.core_sector_addr, bus.core_cmd_type, cyc});
        if (bus.done_valid) begin
            dn_q.push_back('{bus.done_tag, bus.done_error, cyc});
            $display("done tag=%0d err=%0d cyc=%0d", bus.done_tag, bus.done_error, cyc);
        end
        if (prev_new && bus.core_new_cmd) dbl_new <= dbl_new + 1;
        if (prev_done && bus.done_valid) dbl_done <= dbl_done + 1;
        prev_new  <= bus.core_new_cmd;
        prev_done <= bus.done_valid;
    end

    // Core model. 0: normal (ready low ~5 cycles after each pulse), 1: stalled (ready low),
    // 2: deaf (ready stuck high), 3: swallow (drops ready on a pulse, never raises it).
    int mode = 0;
    int busy_cnt = 0;
    int last_rise = 0;
    always @(negedge clk) begin
        if (reset) begin
            bus.core_ready_for_cmd <= 1'b1;
            busy_cnt <= 0;
        end else begin
            case (mode)
                1: bus.core_ready_for_cmd <= 1'b0;
                2: bus.core_ready_for_cmd <= 1'b1;
                3: if (bus.core_new_cmd) bus.core_ready_for_cmd <= 1'b0;
                default: begin
                    if (bus.core_new_cmd) begin
                        bus.core_ready_for_cmd <= 1'b0;
                        busy_cnt <= 5;
                    end else if (busy_cnt > 0) begin
                        busy_cnt <= busy_cnt - 1;
                    end else if (!bus.core_ready_for_cmd) begin
                        bus.core_ready_for_cmd <= 1'b1;
                        last_rise <= cyc;
                    end
                end
            endcase
        end
    end

    // Caller must be at a negedge; returns at the negedge after the accept edge.
    task automatic push(input logic [1:0] t, input logic [31:0] c, input logic [47:0] a,
                        input logic [3:0] g, output int acc);
        int n;
        n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = t;
        bus.cmd_count = c;
        bus.cmd_addr  = a;
        bus.cmd_tag   = g;
        while (!bus.cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) bound_fail("push_accept");
        acc = cyc + 1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int n_exp);
        int n;
        n = 0;
        while (dn_q.size() < n_exp && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) bound_fail("wait_done");
        repeat (10) @(negedge clk);
    endtask

    typedef struct {
        logic [1:0]  typ;
        logic [31:0] cnt;
        logic [47:0] addr;
        logic [3:0]  tag;
        int          n_iss;
        logic [31:0] c0, c1, c2;
        logic [47:0] a0, a1, a2;
        logic        err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int acc;
        int held;
        int n;
        logic [31:0] ec;
        logic [47:0] ea;

        vecs[0] = '{2'd1, 32'd100, 48'h10, 4'd3, 1, 32'd100, 32'd0, 32'd0,
                    48'h10, 48'h0, 48'h0, 1'b0};
        vecs[1] = '{2'd2, 32'd600, 48'hFFFF_FFFF_FF00, 4'd5, 3, 32'd256, 32'd256, 32'd88,
                    48'hFFFF_FFFF_FF00, 48'h0000_0000_0000, 48'h0000_0000_0100, 1'b0};
        vecs[2] = '{2'd0, 32'd0, 48'h1234, 4'd7, 0, 32'd0, 32'd0, 32'd0,
                    48'h0, 48'h0, 48'h0, 1'b1};
        vecs[3] = '{2'd1, 32'd256, 48'h1000, 4'd9, 1, 32'd256, 32'd0, 32'd0,
                    48'h1000, 48'h0, 48'h0, 1'b0};
        vecs[4] = '{2'd0, 32'd257, 48'h2000, 4'd10, 2, 32'd256, 32'd1, 32'd0,
                    48'h2000, 48'h2100, 48'h0, 1'b0};
        vecs[5] = '{2'd3, 32'd1, 48'hFFFF_FFFF_FFFF, 4'd15, 1, 32'd1, 32'd0, 32'd0,
                    48'hFFFF_FFFF_FFFF, 48'h0, 48'h0, 1'b0};

        bus.cmd_valid = 1'b0;
        bus.cmd_type  = '0;
        bus.cmd_count = '0;
        bus.cmd_addr  = '0;
        bus.cmd_tag   = '0;

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_level", 64'(bus.queue_level), 64'd0);
        chk("rst_new_cmd", 64'(bus.core_new_cmd), 64'd0);
        chk("rst_done_valid", 64'(bus.done_valid), 64'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // ---- table of single commands ----
        for (int i = 0; i < 6; i++) begin
            iss_q.delete();
            dn_q.delete();
            push(vecs[i].typ, vecs[i].cnt, vecs[i].addr, vecs[i].tag, acc);
            wait_done(1);
            chk($sformatf("v%0d_n_issue", i), 64'(iss_q.size()), 64'(vecs[i].n_iss));
            for (int k = 0; k < iss_q.size() && k < 3; k++) begin
                ec = (k == 0) ? vecs[i].c0 : (k == 1) ? vecs[i].c1 : vecs[i].c2;
                ea = (k == 0) ? vecs[i].a0 : (k == 1) ? vecs[i].a1 : vecs[i].a2;
                chk($sformatf("v%0d_chunk%0d_count", i, k), 64'(iss_q[k].cnt), 64'(ec));
                chk($sformatf("v%0d_chunk%0d_addr", i, k), 64'(iss_q[k].addr), 64'(ea));
                chk($sformatf("v%0d_chunk%0d_type", i, k), 64'(iss_q[k].typ), 64'(vecs[i].typ));
            end
            if (iss_q.size() > 0)
                chk($sformatf("v%0d_issue_latency", i), 64'(iss_q[0].cyc), 64'(acc + 3));
            chk($sformatf("v%0d_n_done", i), 64'(dn_q.size()), 64'd1);
            if (dn_q.size() > 0) begin
                chk($sformatf("v%0d_done_tag", i), 64'(dn_q[0].tag), 64'(vecs[i].tag));
                chk($sformatf("v%0d_done_err", i), 64'(dn_q[0].err), 64'(vecs[i].err));
                if (vecs[i].n_iss == 0)
                    chk($sformatf("v%0d_done_cycle", i), 64'(dn_q[0].cyc), 64'(acc + 3));
                else
                    chk($sformatf("v%0d_done_cycle", i), 64'(dn_q[0].cyc), 64'(last_rise + 2));
            end
        end

        // ---- backpressure: busy core, four queued, fifth held ----
        iss_q.delete();
        dn_q.delete();
        mode = 1;
        repeat (2) @(negedge clk);
        push(2'd1, 32'd8, 48'h100, 4'd0, acc);
        repeat (4) @(negedge clk);
        for (int k = 1; k <= 4; k++)
            push(2'd1, 32'd8, 48'h100 + 48'(k) * 48'h100, 4'(k), acc);
        chk("bp_level_full", 64'(bus.queue_level), 64'd4);
        chk("bp_cmd_ready_low", 64'(bus.cmd_ready), 64'd0);
        bus.cmd_valid = 1'b1;
        bus.cmd_count = 32'd8;
        bus.cmd_addr  = 48'h600;
        bus.cmd_tag   = 4'd5;
        held = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.cmd_ready) held++;
            @(negedge clk);
        end
        chk("bp_fifth_held", 64'(held), 64'd0);
        chk("bp_level_held", 64'(bus.queue_level), 64'd4);
        mode = 0;
        n = 0;
        while (!bus.cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) bound_fail("bp_fifth_accept");
        acc = cyc + 1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        wait_done(6);
        chk("bp_n_done", 64'(dn_q.size()), 64'd6);
        if (dn_q.size() > 0)
            chk("bp_fifth_after_first_done", 64'(acc > dn_q[0].cyc), 64'd1);
        for (int k = 0; k < dn_q.size(); k++) begin
            chk($sformatf("bp_done%0d_tag", k), 64'(dn_q[k].tag), 64'(k));
            chk($sformatf("bp_done%0d_err", k), 64'(dn_q[k].err), 64'd0);
        end

        // ---- watchdog: core never drops ready for the first command ----
        iss_q.delete();
        dn_q.delete();
        mode = 2;
        repeat (2) @(negedge clk);
        push(2'd2, 32'd10, 48'h500, 4'd2, acc);
        push(2'd2, 32'd20, 48'h600, 4'd4, acc);
        n = 0;
        while (iss_q.size() < 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) bound_fail("to_first_issue");
        @(negedge clk);
        mode = 0;
        wait_done(2);
        chk("to_n_done", 64'(dn_q.size()), 64'd2);
        chk("to_n_issue", 64'(iss_q.size()), 64'd2);
        if (dn_q.size() > 1) begin
            chk("to_done0_tag", 64'(dn_q[0].tag), 64'd2);
            chk("to_done0_err", 64'(dn_q[0].err), 64'd1);
            chk("to_done1_tag", 64'(dn_q[1].tag), 64'd4);
            chk("to_done1_err", 64'(dn_q[1].err), 64'd0);
        end
        if (iss_q.size() > 1) begin
            chk("to_done0_cycle", 64'(dn_q[0].cyc), 64'(iss_q[0].cyc + TMO + 1));
            chk("to_next_count", 64'(iss_q[1].cnt), 64'd20);
            chk("to_next_addr", 64'(iss_q[1].addr), 64'h600);
        end

        // ---- reset during WAIT_DONE with two commands queued ----
        iss_q.delete();
        dn_q.delete();
        mode = 3;
        repeat (2) @(negedge clk);
        push(2'd1, 32'd40, 48'h700, 4'd6, acc);
        push(2'd1, 32'd40, 48'h800, 4'd7, acc);
        push(2'd1, 32'd40, 48'h900, 4'd8, acc);
        n = 0;
        while (iss_q.size() < 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) bound_fail("rst_mid_issue");
        repeat (3) @(negedge clk);
        chk("mid_busy", 64'(bus.busy), 64'd1);
        chk("mid_level", 64'(bus.queue_level), 64'd2);
        #2 reset = 1'b1;
        #1;
        chk("arst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("arst_new_cmd", 64'(bus.core_new_cmd), 64'd0);
        chk("arst_done_valid", 64'(bus.done_valid), 64'd0);
        chk("arst_done_error", 64'(bus.done_error), 64'd0);
        chk("arst_done_tag", 64'(bus.done_tag), 64'd0);
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_level", 64'(bus.queue_level), 64'd0);
        chk("arst_sector_count", 64'(bus.core_sector_count), 64'd0);
        chk("arst_sector_addr", 64'(bus.core_sector_addr), 64'd0);
        chk("arst_cmd_type", 64'(bus.core_cmd_type), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mode = 0;
        repeat (40) @(negedge clk);
        chk("post_rst_no_done", 64'(dn_q.size()), 64'd0);
        chk("post_rst_no_issue", 64'(iss_q.size()), 64'd1);
        chk("post_rst_idle", 64'(bus.busy), 64'd0);

        chk("new_cmd_single_cycle", 64'(dbl_new), 64'd0);
        chk("done_valid_single_cycle", 64'(dbl_done), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit actual=expired required=finish");
        $fatal(1, "time limit");
    end
endmodule
